// File: rtl/ulpi_phy_responder.sv
// PHY side of the ULPI register-access and RX CMD path: answers link TXCMD
// reads/writes with NXT/DIR timing, keeps the immediate register file, and
// drives queued RX CMD bytes.
module ulpi_phy_responder #(
   parameter logic [15:0] VENDOR_ID    = 16'h0424,
   parameter logic [15:0] PRODUCT_ID   = 16'h0009,
   parameter logic [7:0]  FUN_CTRL_RST = 8'h41,
   parameter logic [7:0]  OTG_CTRL_RST = 8'h06
) (
   input  logic       CLK_60M,
   input  logic       NRST_A_USB,
   input  logic [7:0] ULPI_DATA_I,
   output logic [7:0] ULPI_DATA_O,
   output logic       ULPI_DATA_OE,
   output logic       ULPI_DIR,
   output logic       ULPI_NXT,
   input  logic       ULPI_STP,
   input  logic       RXCMD_REQ,
   input  logic [7:0] RXCMD_VAL,
   output logic       RXCMD_DROP,
   output logic [7:0] FUN_CTRL,
   output logic [7:0] OTG_CTRL,
   output logic       PHY_RST
);

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 6;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_W_ACK   = 4'd1;
   localparam logic [3:0] ST_W_DATA  = 4'd2;
   localparam logic [3:0] ST_W_STP   = 4'd3;
   localparam logic [3:0] ST_R_ACK   = 4'd4;
   localparam logic [3:0] ST_R_TA1   = 4'd5;
   localparam logic [3:0] ST_R_DATA  = 4'd6;
   localparam logic [3:0] ST_R_TA2   = 4'd7;
   localparam logic [3:0] ST_RX_TA1  = 4'd8;
   localparam logic [3:0] ST_RX_DATA = 4'd9;
   localparam logic [3:0] ST_RX_TA2  = 4'd10;

   localparam logic [2:0] TGT_NONE = 3'd0;
   localparam logic [2:0] TGT_FUN  = 3'd1;
   localparam logic [2:0] TGT_IFC  = 3'd2;
   localparam logic [2:0] TGT_OTG  = 3'd3;
   localparam logic [2:0] TGT_SCR  = 3'd4;

   localparam logic [1:0] OP_WR  = 2'd0;
   localparam logic [1:0] OP_SET = 2'd1;
   localparam logic [1:0] OP_CLR = 2'd2;

   localparam logic [AW-1:0] ADDR_EXT = 6'h2F;
   // Bit 5 of Function Control is the self-clearing PHY reset request.
   localparam logic [DW-1:0] FUN_MASK = 8'hDF;

   logic [3:0]    r_state, w_state_nxt;
   logic [AW-1:0] r_addr,  w_addr_nxt;
   logic [DW-1:0] r_wdata, w_wdata_nxt;
   logic          r_dir,   w_dir_nxt;
   logic          r_nxt,   w_nxt_nxt;
   logic          r_oe,    w_oe_nxt;
   logic [DW-1:0] r_dout,  w_dout_nxt;
   logic          w_commit;
   logic          w_consume;

   logic          r_pend_vld;
   logic [DW-1:0] r_pend;
   logic          r_drop;
   logic          r_phy_rst;

   logic [DW-1:0] r_fun, r_ifc, r_otg, r_scr;

   logic [2:0]    w_tgt;
   logic [1:0]    w_op;
   logic [DW-1:0] w_cur;
   logic [DW-1:0] w_new;
   logic [DW-1:0] w_rd_data;
   logic          w_is_txcmd;

   // Address decode into target register and alias operation
   always_comb begin
      w_tgt = TGT_NONE;
      w_op  = OP_WR;
      case (r_addr)
         6'h04: begin w_tgt = TGT_FUN; w_op = OP_WR;  end
         6'h05: begin w_tgt = TGT_FUN; w_op = OP_SET; end
         6'h06: begin w_tgt = TGT_FUN; w_op = OP_CLR; end
         6'h07: begin w_tgt = TGT_IFC; w_op = OP_WR;  end
         6'h08: begin w_tgt = TGT_IFC; w_op = OP_SET; end
         6'h09: begin w_tgt = TGT_IFC; w_op = OP_CLR; end
         6'h0A: begin w_tgt = TGT_OTG; w_op = OP_WR;  end
         6'h0B: begin w_tgt = TGT_OTG; w_op = OP_SET; end
         6'h0C: begin w_tgt = TGT_OTG; w_op = OP_CLR; end
         6'h16: begin w_tgt = TGT_SCR; w_op = OP_WR;  end
         6'h17: begin w_tgt = TGT_SCR; w_op = OP_SET; end
         6'h18: begin w_tgt = TGT_SCR; w_op = OP_CLR; end
         default: begin w_tgt = TGT_NONE; w_op = OP_WR; end
      endcase
   end

   // Current value of the addressed register, its post-write value, and read data
   always_comb begin
      w_cur = '0;
      case (w_tgt)
         TGT_FUN: w_cur = r_fun;
         TGT_IFC: w_cur = r_ifc;
         TGT_OTG: w_cur = r_otg;
         TGT_SCR: w_cur = r_scr;
         default: w_cur = '0;
      endcase

      case (w_op)
         OP_SET:  w_new = w_cur | r_wdata;
         OP_CLR:  w_new = w_cur & ~r_wdata;
         default: w_new = r_wdata;
      endcase

      case (r_addr)
         6'h00:   w_rd_data = VENDOR_ID[7:0];
         6'h01:   w_rd_data = VENDOR_ID[15:8];
         6'h02:   w_rd_data = PRODUCT_ID[7:0];
         6'h03:   w_rd_data = PRODUCT_ID[15:8];
         default: w_rd_data = w_cur;
      endcase
   end

   assign w_is_txcmd = ULPI_DATA_I[7] && (ULPI_DATA_I[5:0] != ADDR_EXT);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_dir_nxt   = r_dir;
      w_nxt_nxt   = r_nxt;
      w_oe_nxt    = r_oe;
      w_dout_nxt  = r_dout;
      w_commit    = 1'b0;
      w_consume   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!r_dir && w_is_txcmd) begin
               w_addr_nxt  = ULPI_DATA_I[5:0];
               w_nxt_nxt   = 1'b1;
               w_state_nxt = ULPI_DATA_I[6] ? ST_R_ACK : ST_W_ACK;
            end else if (!r_dir && (ULPI_DATA_I == 8'h00) && r_pend_vld) begin
               w_dir_nxt   = 1'b1;
               w_oe_nxt    = 1'b0;
               w_state_nxt = ST_RX_TA1;
            end
         end
         ST_W_ACK: begin
            if (ULPI_STP) begin
               w_nxt_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_W_DATA;
            end
         end
         ST_W_DATA: begin
            w_nxt_nxt = 1'b0;
            if (ULPI_STP) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_wdata_nxt = ULPI_DATA_I;
               w_state_nxt = ST_W_STP;
            end
         end
         ST_W_STP: begin
            if (ULPI_STP) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_R_ACK: begin
            w_nxt_nxt = 1'b0;
            if (ULPI_STP) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_dir_nxt   = 1'b1;
               w_oe_nxt    = 1'b0;
               w_state_nxt = ST_R_TA1;
            end
         end
         ST_R_TA1: begin
            w_oe_nxt    = 1'b1;
            w_dout_nxt  = w_rd_data;
            w_state_nxt = ST_R_DATA;
         end
         ST_R_DATA: begin
            w_dir_nxt   = 1'b0;
            w_oe_nxt    = 1'b0;
            w_dout_nxt  = '0;
            w_state_nxt = ST_R_TA2;
         end
         ST_RX_TA1: begin
            w_oe_nxt    = 1'b1;
            w_nxt_nxt   = 1'b0;
            w_dout_nxt  = r_pend;
            w_consume   = 1'b1;
            w_state_nxt = ST_RX_DATA;
         end
         ST_RX_DATA: begin
            w_dir_nxt   = 1'b0;
            w_oe_nxt    = 1'b0;
            w_dout_nxt  = '0;
            w_state_nxt = ST_RX_TA2;
         end
         ST_R_TA2, ST_RX_TA2: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_dir_nxt   = 1'b0;
            w_nxt_nxt   = 1'b0;
            w_oe_nxt    = 1'b0;
            w_dout_nxt  = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and bus output registers
   always_ff @(posedge CLK_60M) begin
      if (!NRST_A_USB) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_dir   <= 1'b0;
         r_nxt   <= 1'b0;
         r_oe    <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_dir   <= w_dir_nxt;
         r_nxt   <= w_nxt_nxt;
         r_oe    <= w_oe_nxt;
         r_dout  <= w_dout_nxt;
      end
   end

   // Immediate register file and PHY reset pulse
   always_ff @(posedge CLK_60M) begin
      if (!NRST_A_USB) begin
         r_fun     <= FUN_CTRL_RST & FUN_MASK;
         r_ifc     <= 8'h00;
         r_otg     <= OTG_CTRL_RST;
         r_scr     <= 8'h00;
         r_phy_rst <= 1'b0;
      end else begin
         r_phy_rst <= w_commit && (w_tgt == TGT_FUN) && (w_op != OP_CLR) && r_wdata[5];
         if (w_commit) begin
            case (w_tgt)
               TGT_FUN: r_fun <= w_new & FUN_MASK;
               TGT_IFC: r_ifc <= w_new;
               TGT_OTG: r_otg <= w_new;
               TGT_SCR: r_scr <= w_new;
               default: ;
            endcase
         end
      end
   end

   // One-deep RX CMD slot; a request landing on the consume cycle is not a drop
   always_ff @(posedge CLK_60M) begin
      if (!NRST_A_USB) begin
         r_pend_vld <= 1'b0;
         r_pend     <= '0;
         r_drop     <= 1'b0;
      end else begin
         r_drop <= RXCMD_REQ && r_pend_vld && !w_consume;
         if (RXCMD_REQ) begin
            r_pend_vld <= 1'b1;
            r_pend     <= RXCMD_VAL;
         end else if (w_consume) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   assign ULPI_DATA_O  = r_dout;
   assign ULPI_DATA_OE = r_oe;
   assign ULPI_DIR     = r_dir;
   assign ULPI_NXT     = r_nxt;
   assign RXCMD_DROP   = r_drop;
   assign FUN_CTRL     = r_fun;
   assign OTG_CTRL     = r_otg;
   assign PHY_RST      = r_phy_rst;

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Scoreboard bench for ulpi_phy_responder: directed cases then randomized
// transactions, checked against a register-map model.
module tb_ulpi_phy_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic [7:0] data_o;
   logic       oe, dir, nxt;
   logic       stp = 1'b0;
   logic       rx_req = 1'b0;
   logic [7:0] rx_val = 8'h00;
   logic       rx_drop, phy_rst;
   logic [7:0] fun_ctrl, otg_ctrl;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_rst = 0, obs_rst = 0;
   int exp_drop = 0, obs_drop = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_byte;
   logic [7:0] m_reg[4];

   ulpi_phy_responder dut (
      .CLK_60M(clk), .NRST_A_USB(rst_n),
      .ULPI_DATA_I(data_i), .ULPI_DATA_O(data_o), .ULPI_DATA_OE(oe),
      .ULPI_DIR(dir), .ULPI_NXT(nxt), .ULPI_STP(stp),
      .RXCMD_REQ(rx_req), .RXCMD_VAL(rx_val), .RXCMD_DROP(rx_drop),
      .FUN_CTRL(fun_ctrl), .OTG_CTRL(otg_ctrl), .PHY_RST(phy_rst)
   );

   always #8 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: every PHY-driven data byte is popped from the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (dir && oe) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL bus_byte: got %02h with nothing expected", data_o);
            end else begin
               exp_byte = exp_q.pop_front();
               check("bus_byte", 32'(data_o), 32'(exp_byte));
            end
         end
         if (phy_rst) obs_rst++;
         if (rx_drop) obs_drop++;
      end
   end

   // Reference register map
   function automatic bit m_decode(input logic [5:0] a, output int idx, output int op);
      int ai;
      ai = int'(a);
      idx = 0;
      op = 0;
      if (ai >= 4 && ai <= 12) begin idx = (ai - 4) / 3; op = (ai - 4) % 3; return 1'b1; end
      if (ai >= 22 && ai <= 24) begin idx = 3; op = ai - 22; return 1'b1; end
      return 1'b0;
   endfunction

   function automatic logic [7:0] m_read(input logic [5:0] a);
      logic [31:0] ids;
      int idx, op;
      ids = {16'h0009, 16'h0424};
      if (a <= 6'd3) return ids[int'(a)*8 +: 8];
      if (m_decode(a, idx, op)) return m_reg[idx];
      return 8'h00;
   endfunction

   function automatic bit m_write(input logic [5:0] a, input logic [7:0] d);
      int idx, op;
      bit pulse;
      pulse = 1'b0;
      if (!m_decode(a, idx, op)) return 1'b0;
      case (op)
         0:       m_reg[idx] = d;
         1:       m_reg[idx] = m_reg[idx] | d;
         default: m_reg[idx] = m_reg[idx] & ~d;
      endcase
      if (idx == 0) begin
         pulse = (op != 2) && d[5];
         m_reg[0] = m_reg[0] & 8'hDF;
      end
      return pulse;
   endfunction

   function automatic void m_reset();
      m_reg[0] = 8'h41;
      m_reg[1] = 8'h00;
      m_reg[2] = 8'h06;
      m_reg[3] = 8'h00;
   endfunction

   task automatic chk_reset();
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_nxt", 32'(nxt), 32'd0);
      check("rst_oe", 32'(oe), 32'd0);
      check("rst_data_o", 32'(data_o), 32'd0);
      check("rst_drop", 32'(rx_drop), 32'd0);
      check("rst_phy_rst", 32'(phy_rst), 32'd0);
      check("rst_fun", 32'(fun_ctrl), 32'h41);
      check("rst_otg", 32'(otg_ctrl), 32'h06);
   endtask

   // abort_at: 0 none, 1 STP in W_ACK, 2 STP in W_DATA
   task automatic wr(input logic [5:0] a, input logic [7:0] d, input int abort_at, input int stp_wait);
      bit pulse;
      @(posedge clk); #1 data_i = {2'b10, a};
      @(posedge clk); #1 data_i = 8'h00;
      check("w_ack_nxt", 32'(nxt), 32'd1);
      if (abort_at == 1) begin
         stp = 1'b1;
         @(posedge clk); #1 stp = 1'b0;
         check("w_abort_ack_nxt", 32'(nxt), 32'd0);
         check("w_abort_ack_fun", 32'(fun_ctrl), 32'(m_reg[0]));
         return;
      end
      @(posedge clk); #1 data_i = d;
      check("w_data_nxt", 32'(nxt), 32'd1);
      if (abort_at == 2) begin
         stp = 1'b1;
         @(posedge clk); #1 stp = 1'b0; data_i = 8'h00;
         check("w_abort_data_nxt", 32'(nxt), 32'd0);
         check("w_abort_data_fun", 32'(fun_ctrl), 32'(m_reg[0]));
         check("w_abort_data_otg", 32'(otg_ctrl), 32'(m_reg[2]));
         return;
      end
      @(posedge clk); #1 data_i = 8'h00;
      check("w_stp_nxt", 32'(nxt), 32'd0);
      repeat (stp_wait) @(posedge clk);
      #1 stp = 1'b1;
      @(posedge clk); #1 stp = 1'b0;
      pulse = m_write(a, d);
      if (pulse) exp_rst++;
      check("w_phy_rst", 32'(phy_rst), 32'(pulse));
      check("w_fun", 32'(fun_ctrl), 32'(m_reg[0]));
      check("w_otg", 32'(otg_ctrl), 32'(m_reg[2]));
   endtask

   task automatic rd(input logic [5:0] a);
      @(posedge clk); #1 data_i = {2'b11, a};
      exp_q.push_back(m_read(a));
      @(posedge clk); #1 data_i = 8'h00;
      check("r_ack_nxt", 32'(nxt), 32'd1);
      @(posedge clk); #1;
      check("r_ta1_dir_oe_nxt", 32'({dir, oe, nxt}), 32'b100);
      @(posedge clk); #1;
      check("r_data_dir_oe", 32'({dir, oe}), 32'b11);
      @(posedge clk); #1;
      check("r_ta2_dir_oe", 32'({dir, oe}), 32'b00);
   endtask

   task automatic ign(input logic [7:0] v);
      @(posedge clk); #1 data_i = v;
      @(posedge clk); #1 data_i = 8'h00;
      check("ignored_cmd_nxt_dir", 32'({nxt, dir}), 32'd0);
   endtask

   // Waits for k completed PHY bus turns (DIR falling), bounded
   task automatic wait_rx(input int k);
      int falls, cyc;
      logic prev;
      falls = 0;
      cyc = 0;
      prev = dir;
      while (falls < k && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (prev && !dir) falls++;
         prev = dir;
      end
      check("rx_turns_seen", 32'(falls), 32'(k));
   endtask

   // gap 0: back-to-back requests (second overwrites); gap 1: second lands on consume
   task automatic rx_burst(input int gap, input logic [7:0] v1, input logic [7:0] v2);
      @(posedge clk); #1 rx_req = 1'b1; rx_val = v1;
      if (gap == 0) begin
         @(posedge clk); #1 rx_val = v2;
         exp_drop++;
         exp_q.push_back(v2);
         @(posedge clk); #1 rx_req = 1'b0;
         wait_rx(1);
      end else begin
         exp_q.push_back(v1);
         @(posedge clk); #1 rx_req = 1'b0;
         @(posedge clk); #1 rx_req = 1'b1; rx_val = v2;
         exp_q.push_back(v2);
         @(posedge clk); #1 rx_req = 1'b0;
         wait_rx(2);
      end
   endtask

   function automatic logic [5:0] rnd_addr();
      int unsigned r;
      logic [5:0] a;
      r = $urandom_range(0, 3);
      if (r < 2) a = 6'($urandom_range(0, 12));
      else if (r == 2) a = 6'($urandom_range(22, 24));
      else a = 6'($urandom_range(0, 63));
      if (a == 6'h2F) a = 6'h2E;
      return a;
   endfunction

   initial begin
      int cnt;
      int unsigned op, ab;
      logic [7:0] v;

      m_reset();
      repeat (3) @(posedge clk);
      #1 chk_reset();
      rst_n = 1'b1;

      rd(6'h04);
      wr(6'h16, 8'hA5, 0, 0);
      wr(6'h17, 8'h0A, 0, 2);
      wr(6'h18, 8'h80, 0, 0);
      rd(6'h16);
      wr(6'h04, 8'h5A, 2, 0);
      wr(6'h04, 8'h13, 1, 0);
      wr(6'h04, 8'h20, 0, 0);
      rd(6'h04);
      ign(8'h40);
      ign(8'hAF);
      ign(8'hEF);
      ign(8'h05);

      // Two RX CMD requests while a read is in flight
      fork
         rd(6'h00);
         begin
            @(posedge clk); @(posedge clk); #1 rx_req = 1'b1; rx_val = 8'h4C;
            @(posedge clk); #1 rx_val = 8'h4E;
            @(posedge clk); #1 rx_req = 1'b0;
         end
      join
      exp_q.push_back(8'h4E);
      exp_drop++;
      cnt = 0;
      while (!dir && cnt < 10) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("rx_after_read_latency", 32'(cnt), 32'd2);
      wait_rx(1);

      rx_burst(1, 8'h11, 8'h22);
      rx_burst(0, 8'h33, 8'h44);

      for (int i = 0; i < 200; i++) begin
         op = $urandom_range(0, 3);
         case (op)
            0: begin
               ab = $urandom_range(0, 5);
               wr(rnd_addr(), 8'($urandom), (ab == 0) ? 1 : (ab == 1) ? 2 : 0,
                  int'($urandom_range(0, 2)));
            end
            1: rd(rnd_addr());
            2: rx_burst(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            default: begin
               ab = $urandom_range(0, 3);
               if (ab == 0) v = {2'b01, 6'($urandom)};
               else if (ab == 1) v = {2'b00, 6'($urandom_range(1, 63))};
               else if (ab == 2) v = 8'hAF;
               else v = 8'hEF;
               ign(v);
            end
         endcase
      end

      // Reset in the middle of a write
      wr(6'h0A, 8'h3C, 0, 0);
      @(posedge clk); #1 data_i = {2'b10, 6'h04};
      @(posedge clk); #1 data_i = 8'h00; rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset();
      rst_n = 1'b1;
      m_reset();
      rd(6'h07);
      rd(6'h16);
      rd(6'h0C);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("phy_rst_pulse_cycles", 32'(obs_rst), 32'(exp_rst));
      check("rxcmd_drop_pulses", 32'(obs_drop), 32'(exp_drop));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
